video_frame_check: RTL and testbench

VIDEO_FRAME_CHECK -- requirements
Module: video_frame_check

---
 rtl/video_frame_check_pkg.sv | 29 ++
 rtl/video_frame_check_skid_buf.sv | 80 ++++++++
 rtl/video_frame_check.sv | 131 +++++++++++++
 tb/tb_video_frame_check.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_frame_check_pkg.sv
// Shared video package: FSM encoding, default frame geometry, beat payload
// layout and a saturating counter helper for video_frame_check.
package video_frame_check_pkg;

   localparam int unsigned H_ACTIVE_DEF = 1280;
   localparam int unsigned V_ACTIVE_DEF = 720;
   localparam int unsigned PIX_W        = 24;
   localparam int unsigned CNT_W        = 16;

   typedef enum logic {
      WAIT_SOF = 1'b0,
      ACTIVE   = 1'b1
   } vfc_state_e;

   // Payload carried through the skid buffer
   typedef struct packed {
      logic             tuser;
      logic             tlast;
      logic [PIX_W-1:0] tdata;
   } vfc_beat_t;

   localparam int unsigned BEAT_W = $bits(vfc_beat_t);

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/video_frame_check_skid_buf.sv
// axis_skid_buf: two-entry AXI-Stream skid buffer. Entry 0 drives the output
// directly; entry 1 absorbs a beat when the output stalls. s_ready is a
// register computed from the next occupancy, so m_ready never reaches it
// combinationally.
module axis_skid_buf #(
   parameter int unsigned W = 26
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [W-1:0] s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [W-1:0] m_data
);

   logic         v1_q;
   logic [W-1:0] d1_q;
   logic         v0_n, v1_n;
   logic [W-1:0] d0_n, d1_n;
   logic         push_c, pop_c;

   assign push_c = s_valid & s_ready;
   assign pop_c  = m_valid & m_ready;

   // Next-state of both entries from the push/pop combination
   always_comb begin
      v0_n = m_valid;
      v1_n = v1_q;
      d0_n = m_data;
      d1_n = d1_q;
      case ({push_c, pop_c})
         2'b11: begin
            if (v1_q) begin
               d0_n = d1_q;
               d1_n = s_data;
            end else begin
               d0_n = s_data;
            end
         end
         2'b01: begin
            if (v1_q) begin
               d0_n = d1_q;
               v1_n = 1'b0;
            end else begin
               v0_n = 1'b0;
            end
         end
         2'b10: begin
            if (!m_valid) begin
               d0_n = s_data;
               v0_n = 1'b1;
            end else begin
               d1_n = s_data;
               v1_n = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Entry registers and registered ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         v1_q    <= 1'b0;
         d1_q    <= '0;
         s_ready <= 1'b0;
      end else begin
         m_valid <= v0_n;
         m_data  <= d0_n;
         v1_q    <= v1_n;
         d1_q    <= d1_n;
         s_ready <= ~(v0_n & v1_n);
      end
   end

endmodule

// File: rtl/video_frame_check.sv
// video_frame_check: passes an AXI-Stream video stream through a skid buffer
// while checking frame structure (SOF/EOL placement, line length, line
// count) and counting completed frames.
// Optional build macro VFC_SYNC_DROP_EN: beats accepted while waiting for
// SOF without tuser are consumed instead of forwarded.
module video_frame_check
   import video_frame_check_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   output logic              s_axis_video_tready,
   input  logic [PIX_W-1:0]  s_axis_video_tdata,
   input  logic              s_axis_video_tvalid,
   input  logic              s_axis_video_tuser,
   input  logic              s_axis_video_tlast,
   input  logic              m_axis_video_tready,
   output logic [PIX_W-1:0]  m_axis_video_tdata,
   output logic              m_axis_video_tvalid,
   output logic              m_axis_video_tuser,
   output logic              m_axis_video_tlast,
   input  logic              clr_err,
   output logic              frame_done,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic              err_line_len,
   output logic              err_frame_len,
   output logic              err_no_sof
);

   vfc_state_e       state_q, state_n;
   logic [CNT_W-1:0] px_q, px_n;
   logic [CNT_W-1:0] ln_q, ln_n;
   logic [CNT_W-1:0] fc_n;
   logic             fd_n, e_line_n, e_frame_n, e_nosof_n;
   logic             acc_c, drop_c;
   vfc_beat_t        in_beat, out_beat;

   assign acc_c = s_axis_video_tvalid & s_axis_video_tready;

`ifdef VFC_SYNC_DROP_EN
   assign drop_c = (state_q == WAIT_SOF) & ~s_axis_video_tuser;
`else
   assign drop_c = 1'b0;
`endif

   assign in_beat.tuser = s_axis_video_tuser;
   assign in_beat.tlast = s_axis_video_tlast;
   assign in_beat.tdata = s_axis_video_tdata;

   axis_skid_buf #(
      .W (BEAT_W)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_axis_video_tvalid & ~drop_c),
      .s_ready (s_axis_video_tready),
      .s_data  (in_beat),
      .m_valid (m_axis_video_tvalid),
      .m_ready (m_axis_video_tready),
      .m_data  (out_beat)
   );

   assign m_axis_video_tdata = out_beat.tdata;
   assign m_axis_video_tuser = out_beat.tuser;
   assign m_axis_video_tlast = out_beat.tlast;

   // Frame tracking: SOF handling first, then end-of-line accounting
   always_comb begin
      state_n   = state_q;
      px_n      = px_q;
      ln_n      = ln_q;
      fc_n      = frame_cnt;
      fd_n      = 1'b0;
      e_line_n  = err_line_len  & ~clr_err;
      e_frame_n = err_frame_len & ~clr_err;
      e_nosof_n = err_no_sof    & ~clr_err;
      if (acc_c) begin
         if (state_q == WAIT_SOF) begin
            if (s_axis_video_tuser) begin
               px_n    = CNT_W'(1);
               ln_n    = '0;
               state_n = ACTIVE;
            end else begin
               e_nosof_n = 1'b1;
            end
         end else if (s_axis_video_tuser) begin
            if (ln_q != CNT_W'(V_ACTIVE)) e_frame_n = 1'b1;
            px_n = CNT_W'(1);
            ln_n = '0;
         end else begin
            px_n = sat_inc(px_q);
         end
         if ((state_n == ACTIVE) && s_axis_video_tlast) begin
            if (px_n != CNT_W'(H_ACTIVE)) e_line_n = 1'b1;
            px_n = '0;
            ln_n = sat_inc(ln_n);
            if (ln_n == CNT_W'(V_ACTIVE)) begin
               fd_n    = 1'b1;
               fc_n    = frame_cnt + CNT_W'(1);
               state_n = WAIT_SOF;
            end
         end
      end
   end

   // State, counters and status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= WAIT_SOF;
         px_q          <= '0;
         ln_q          <= '0;
         frame_cnt     <= '0;
         frame_done    <= 1'b0;
         err_line_len  <= 1'b0;
         err_frame_len <= 1'b0;
         err_no_sof    <= 1'b0;
      end else begin
         state_q       <= state_n;
         px_q          <= px_n;
         ln_q          <= ln_n;
         frame_cnt     <= fc_n;
         frame_done    <= fd_n;
         err_line_len  <= e_line_n;
         err_frame_len <= e_frame_n;
         err_no_sof    <= e_nosof_n;
      end
   end

endmodule

// File: tb/tb_video_frame_check.sv
// Directed bench for video_frame_check (H_ACTIVE=4, V_ACTIVE=2) with a
// scoreboard queue of expected output beats.
module tb_video_frame_check;

   localparam int H = 4;
   localparam int V = 2;
`ifdef VFC_SYNC_DROP_EN
   localparam int NOSOF_FWD = 0;
`else
   localparam int NOSOF_FWD = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_tready;
   logic [23:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tuser = 1'b0;
   logic        s_tlast = 1'b0;
   logic        m_tready = 1'b1;
   logic [23:0] m_tdata;
   logic        m_tvalid;
   logic        m_tuser;
   logic        m_tlast;
   logic        clr_err = 1'b0;
   logic        frame_done;
   logic [15:0] frame_cnt;
   logic        err_line_len;
   logic        err_frame_len;
   logic        err_no_sof;

   typedef struct packed {
      logic [23:0] d;
      logic        u;
      logic        l;
      logic [31:0] cyc;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          rel_cnt = 0;
   int          out_cnt = 0;
   int          fd_cnt = 0;
   int          end_cyc = -10;
   int          mdl_ln = 0;
   bit          mdl_wait = 1'b1;
   bit          chk_lat = 1'b0;
   bit          tog = 1'b0;
   bit          saw_full = 1'b0;
   bit          prev_stall = 1'b0;
   logic [25:0] prev_pl = '0;

   video_frame_check #(
      .H_ACTIVE (H),
      .V_ACTIVE (V)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .s_axis_video_tready (s_tready),
      .s_axis_video_tdata  (s_tdata),
      .s_axis_video_tvalid (s_tvalid),
      .s_axis_video_tuser  (s_tuser),
      .s_axis_video_tlast  (s_tlast),
      .m_axis_video_tready (m_tready),
      .m_axis_video_tdata  (m_tdata),
      .m_axis_video_tvalid (m_tvalid),
      .m_axis_video_tuser  (m_tuser),
      .m_axis_video_tlast  (m_tlast),
      .clr_err             (clr_err),
      .frame_done          (frame_done),
      .frame_cnt           (frame_cnt),
      .err_line_len        (err_line_len),
      .err_frame_len       (err_frame_len),
      .err_no_sof          (err_no_sof)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor at negedge: handshakes seen here complete on the next posedge
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         mdl_wait   = 1'b1;
         mdl_ln     = 0;
         prev_stall = 1'b0;
         rel_cnt    = 0;
      end else begin
         exp_t e;
         bit   drop;
         if (rel_cnt < 100) rel_cnt++;
         if (rel_cnt >= 2) begin
            chk("s_tready_vs_occupancy", 32'(s_tready), 32'(q.size() < 2));
            if (!s_tready) saw_full = 1'b1;
         end
         if (prev_stall) begin
            chk("hold_tvalid", 32'(m_tvalid), 32'd1);
            chk("hold_payload", 32'({m_tdata, m_tuser, m_tlast}), 32'(prev_pl));
         end
         prev_stall = m_tvalid && !m_tready;
         prev_pl    = {m_tdata, m_tuser, m_tlast};
         if (frame_done) begin
            fd_cnt++;
            chk("frame_done_timing", 32'(cyc), 32'(end_cyc + 1));
         end
         if (m_tvalid && m_tready) begin
            out_cnt++;
            checks++;
            assert (q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_beat observed=%0h expected=none", m_tdata);
            end
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("out_beat", 32'({m_tdata, m_tuser, m_tlast}), 32'({e.d, e.u, e.l}));
               if (chk_lat) chk("latency", 32'(cyc), e.cyc + 32'd1);
            end
         end
         if (s_tvalid && s_tready) begin
            drop = 1'b0;
`ifdef VFC_SYNC_DROP_EN
            drop = mdl_wait && !s_tuser;
`endif
            if (mdl_wait) begin
               if (s_tuser) begin
                  mdl_wait = 1'b0;
                  mdl_ln   = 0;
               end
            end else if (s_tuser) begin
               mdl_ln = 0;
            end
            if (!mdl_wait && s_tlast) begin
               mdl_ln++;
               if (mdl_ln == V) begin
                  mdl_wait = 1'b1;
                  end_cyc  = cyc;
               end
            end
            if (!drop) q.push_back('{d: s_tdata, u: s_tuser, l: s_tlast, cyc: 32'(cyc)});
         end
         cyc++;
      end
   end

   // Drive one beat and hold it until accepted; call at posedge+1
   task automatic send(input logic [23:0] d, input logic u, input logic l);
      bit ok;
      int t;
      t        = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tuser  = u;
      s_tlast  = l;
      do begin
         @(negedge clk);
         ok = s_tready;
         @(posedge clk);
         #1;
         if (tog) m_tready = ~m_tready;
         t++;
      end while (!ok && t < 100);
      checks++;
      assert (ok) else begin
         errors++;
         $error("FAIL send_timeout observed=%0d expected=accept", t);
      end
      s_tvalid = 1'b0;
      s_tuser  = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_frame(input logic [23:0] base);
      for (int i = 0; i < H * V; i++)
         send(base + 24'(i), i == 0, (i % H) == H - 1);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((q.size() != 0 || m_tvalid) && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      checks++;
      assert (t < 200) else begin
         errors++;
         $error("FAIL drain_timeout observed=%0d expected=empty", q.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
   endtask

   // Hold reset, check reset values, release and check ready timing
   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_tready", 32'(s_tready), 32'd0);
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_m_payload", 32'({m_tdata, m_tuser, m_tlast}), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_errs", 32'({err_line_len, err_frame_len, err_no_sof}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_tready_before_edge", 32'(s_tready), 32'd0);
      @(posedge clk);
      #1;
      chk("rel_tready_after_edge", 32'(s_tready), 32'd1);
   endtask

   initial begin
      int fd0;
      int oc0;

      @(posedge clk);
      #1;
      do_reset();

      // Clean frame, free-flowing output, latency 1
      chk_lat  = 1'b1;
      fd0      = fd_cnt;
      send_frame(24'h000100);
      wait_idle();
      chk_lat  = 1'b0;
      chk("t1_frame_done_pulses", 32'(fd_cnt - fd0), 32'd1);
      chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("t1_errs", 32'({err_line_len, err_frame_len, err_no_sof}), 32'd0);

      // Same frame with output ready toggling every cycle
      fd0      = fd_cnt;
      saw_full = 1'b0;
      tog      = 1'b1;
      send_frame(24'h000200);
      tog      = 1'b0;
      m_tready = 1'b1;
      wait_idle();
      chk("t2_saw_full", 32'(saw_full), 32'd1);
      chk("t2_frame_done_pulses", 32'(fd_cnt - fd0), 32'd1);
      chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);
      chk("t2_errs", 32'({err_line_len, err_frame_len, err_no_sof}), 32'd0);

      // Short line of 3 beats
      send(24'h000300, 1'b1, 1'b0);
      send(24'h000301, 1'b0, 1'b0);
      send(24'h000302, 1'b0, 1'b1);
      wait_idle();
      chk("t3_err_line_len", 32'(err_line_len), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("t3_err_line_sticky", 32'(err_line_len), 32'd1);
      chk("t3_err_frame_len", 32'(err_frame_len), 32'd0);
      pulse_clr();
      chk("t3_err_line_cleared", 32'(err_line_len), 32'd0);

      // SOF after a single line, then a correct frame
      fd0 = fd_cnt;
      send_frame(24'h000400);
      wait_idle();
      chk("t4_err_frame_len", 32'(err_frame_len), 32'd1);
      chk("t4_err_line_len", 32'(err_line_len), 32'd0);
      chk("t4_frame_cnt", 32'(frame_cnt), 32'd3);
      chk("t4_frame_done_pulses", 32'(fd_cnt - fd0), 32'd1);
      pulse_clr();
      chk("t4_err_frame_cleared", 32'(err_frame_len), 32'd0);

      // Beats without SOF after reset
      do_reset();
      oc0 = out_cnt;
      send(24'h000500, 1'b0, 1'b0);
      send(24'h000501, 1'b0, 1'b0);
      wait_idle();
      chk("t5_err_no_sof", 32'(err_no_sof), 32'd1);
      chk("t5_beats_out", 32'(out_cnt - oc0), 32'(2 * NOSOF_FWD));
      clr_err = 1'b1;
      send(24'h000502, 1'b0, 1'b0);
      clr_err = 1'b0;
      chk("t5_clr_and_set", 32'(err_no_sof), 32'd1);
      wait_idle();
      chk("t5_beats_out_3", 32'(out_cnt - oc0), 32'(3 * NOSOF_FWD));
      pulse_clr();
      chk("t5_err_no_sof_cleared", 32'(err_no_sof), 32'd0);

      // Reset mid-line with the buffer full
      m_tready = 1'b0;
      send(24'h000600, 1'b1, 1'b0);
      send(24'h000601, 1'b0, 1'b0);
      s_tvalid = 1'b1;
      s_tdata  = 24'h000602;
      @(posedge clk);
      #1;
      chk("t6_full_tready", 32'(s_tready), 32'd0);
      chk("t6_full_mvalid", 32'(m_tvalid), 32'd1);
      chk("t6_full_mdata", 32'(m_tdata), 32'h000600);
      rst = 1'b1;
      #1;
      chk("t6_rst_mvalid", 32'(m_tvalid), 32'd0);
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      do_reset();
      fd0 = fd_cnt;
      send_frame(24'h000700);
      wait_idle();
      chk("t6_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("t6_frame_done_pulses", 32'(fd_cnt - fd0), 32'd1);
      chk("t6_errs", 32'({err_line_len, err_frame_len, err_no_sof}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
